// File: rtl/minaret_pkg.sv
// Shared definitions for the minaret instruction fetch unit.
//   ADDR_W / INST_W  : address and instruction widths
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : fetch controller states
//   word_align       : clears the byte-offset bits of an address
package minaret_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/minaret_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// Ports:
//   clk, reset (async, active-low)
//   push / push_data : write an entry (ignored when full unless popping)
//   pop              : drop the head entry (ignored when empty)
//   flush            : discard all entries; wins over push and pop
//   head             : oldest entry
//   count / empty    : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module minaret_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/minaret_fetch.sv
// Instruction fetch unit for the minaret core.
// Generates sequential word-aligned fetch addresses, issues them on a
// valid/ready memory bus, buffers in-order responses and presents them to
// the core as inst/inst_pc/inst_valid. A redirect flushes the buffer,
// restarts fetch at the new target and drops responses still in flight.
// Ports:
//   clk, reset (async, active-low)
//   imem_req_valid/ready/addr : fetch request channel
//   imem_rsp_valid/data       : in-order responses, always accepted
//   inst_valid/inst/inst_pc   : instruction to core, inst_ready consumes
//   redirect_valid/pc         : restart fetch at redirect_pc (word aligned)
// Build option MINA_FETCH_BYPASS_EN: a kept response arriving while the
// buffer is empty is presented to the core in the same cycle.
//
// State  | meaning
// BOOT   | first cycle after reset, no requests
// FETCH  | issuing requests, keeping responses
// DRAIN  | waiting for stale responses after a redirect, dropping them
module minaret_fetch
    import minaret_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e               state_q, state_d;
    logic [ADDR_W-1:0]          pc_q, pc_d;
    logic [CW-1:0]              out_q, out_d;

    logic [CW-1:0]              fifo_count;
    logic                       fifo_empty;
    logic                       fifo_push, fifo_pop;
    logic [ADDR_W+INST_W-1:0]   fifo_head;
    logic [CW:0]                credit_used;
    logic [ADDR_W-1:0]          rsp_pc;
    logic                       req_valid, req_fire;
    logic                       rsp_keep, rsp_dec;
    logic                       bypass;

    // A pop this cycle frees its slot in time for a request accepted now,
    // which keeps a 1-cycle memory streaming without bubbles.
    assign credit_used = {1'b0, out_q} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};
    assign req_valid   = (state_q == ST_FETCH) && !redirect_valid && (credit_used < DEPTH_C);
    assign req_fire    = req_valid && imem_req_ready;

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;

    // In FETCH all outstanding requests are consecutive words ending just
    // below pc_q, so the oldest one is pc_q - 4*outstanding.
    assign rsp_pc   = pc_q - {{(ADDR_W-CW-2){1'b0}}, out_q, 2'b00};
    assign rsp_keep = imem_rsp_valid && (state_q == ST_FETCH) && !redirect_valid;
    assign rsp_dec  = imem_rsp_valid && (out_q != '0);

`ifdef MINA_FETCH_BYPASS_EN
    assign bypass = rsp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_pop   = !fifo_empty && inst_ready;
    assign fifo_push  = rsp_keep && !(bypass && inst_ready);
    assign inst_valid = !fifo_empty || bypass;

    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (!fifo_empty) begin
            inst_pc = fifo_head[ADDR_W+INST_W-1:INST_W];
            inst    = fifo_head[INST_W-1:0];
        end else if (bypass) begin
            inst_pc = rsp_pc;
            inst    = imem_rsp_data;
        end
    end

    minaret_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        out_d = out_q;
        if (req_fire && !rsp_dec) begin
            out_d = out_q + CW'(1);
        end else if (!req_fire && rsp_dec) begin
            out_d = out_q - CW'(1);
        end

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (redirect_valid && (out_d != '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_d == '0) begin
                    state_d = ST_FETCH;
                end
            end
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_minaret_fetch.sv
module tb_minaret_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef MINA_FETCH_BYPASS_EN
    localparam int          EXP_LAT  = 0;
`else
    localparam int          EXP_LAT  = 1;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    minaret_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    int          epoch;
    int          cyc;
    logic [31:0] exp_pc;
    logic [31:0] fetch_pc;
    int          n_assert;
    int          n_fail;
    int          delivered;

    int          p_ird, p_rrdy, p_rsp, p_redir, lat_min, lat_max;
    bit          force_redir;
    logic [31:0] force_pc;
    bit          after_redirect;
    bit          chk_bubble, chk_stall, chk_hold, track_lat;
    bit          saw_wrap_req, saw_wrap_inst;
    int          first_rsp, first_vld;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_valid"},  {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"},   imem_req_addr, RESET_PC);
        chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},       inst, 32'd0);
        chk({tag, "_inst_pc"},    inst_pc, 32'd0);
    endtask

    // Entered and left at posedge+1; drives inputs, checks at negedge,
    // then advances the reference model across the next rising edge.
    task automatic cycle();
        bit          stale;
        logic [31:0] rpc;
        inst_ready     = ($urandom_range(99, 0) < p_ird);
        imem_req_ready = ($urandom_range(99, 0) < p_rrdy);
        redirect_valid = force_redir || ($urandom_range(999, 0) < p_redir);
        redirect_pc    = force_redir ? force_pc : $urandom;
        force_redir    = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99, 0) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end

        @(negedge clk);
        stale = 1'b0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale = 1'b1;

        if (after_redirect)
            chk("inst_valid_after_redirect", {31'd0, inst_valid}, 32'd0);
        if (redirect_valid || stale)
            chk("req_blocked", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid)
            chk("req_addr", imem_req_addr, fetch_pc);
        if (chk_bubble)
            chk("no_bubble", {31'd0, inst_valid}, 32'd1);
        if (chk_stall) begin
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
            chk("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
        end
        if (chk_hold)
            chk("held_req_valid", {31'd0, imem_req_valid}, 32'd1);
        if (track_lat) begin
            if (imem_rsp_valid && first_rsp < 0) first_rsp = cyc;
            if (inst_valid && first_vld < 0) first_vld = cyc;
        end
        if (imem_req_valid && imem_req_addr == 32'h0 && fetch_pc == 32'h0 && epoch > 0)
            saw_wrap_req = 1'b1;

        if (inst_valid && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, mem_word(exp_pc));
            if (inst_pc == 32'h0 && delivered > 0) saw_wrap_inst = 1'b1;
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end

        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: fetch_pc, due: cyc + $urandom_range(lat_max, lat_min), epoch: epoch});
            fetch_pc = fetch_pc + 32'd4;
        end
        chk("outstanding_bound", {31'd0, (mq.size() <= DEPTH)}, 32'd1);
        if (redirect_valid) begin
            rpc      = redirect_pc & 32'hFFFF_FFFC;
            exp_pc   = rpc;
            fetch_pc = rpc;
            epoch++;
        end
        after_redirect = redirect_valid;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_mode(input int ird, input int rrdy, input int rsp, input int redir,
                            input int lmin, input int lmax);
        p_ird = ird; p_rrdy = rrdy; p_rsp = rsp; p_redir = redir;
        lat_min = lmin; lat_max = lmax;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check_reset_values("midrst");
        mq.delete();
        exp_pc         = RESET_PC;
        fetch_pc       = RESET_PC;
        after_redirect = 1'b0;
        epoch++;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc++;
    endtask

    initial begin
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        n_assert = 0; n_fail = 0; delivered = 0; cyc = 0; epoch = 0;
        exp_pc = RESET_PC; fetch_pc = RESET_PC;
        force_redir = 1'b0; force_pc = '0; after_redirect = 1'b0;
        chk_bubble = 1'b0; chk_stall = 1'b0; chk_hold = 1'b0; track_lat = 1'b0;
        saw_wrap_req = 1'b0; saw_wrap_inst = 1'b0;
        first_rsp = -1; first_vld = -1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b1;

        // Streaming: full-rate memory with 1-cycle latency.
        set_mode(100, 100, 100, 0, 1, 1);
        track_lat = 1'b1;
        run(5);
        track_lat  = 1'b0;
        chk("rsp_to_inst_latency", first_vld - first_rsp, EXP_LAT);
        chk_bubble = 1'b1;
        run(20);
        chk_bubble = 1'b0;

        // Core stalls for 10 cycles: buffer fills, requests stop.
        set_mode(0, 100, 100, 0, 1, 1);
        run(9);
        chk_stall = 1'b1;
        run(1);
        chk_stall = 1'b0;
        set_mode(100, 100, 100, 0, 1, 1);
        run(10);

        // Memory refuses requests for 3 cycles: address held.
        set_mode(100, 0, 100, 0, 1, 1);
        run(2);
        chk_hold = 1'b1;
        run(1);
        chk_hold = 1'b0;
        set_mode(100, 100, 100, 0, 1, 1);
        run(10);

        // Redirect to an unaligned target with fetches in flight.
        set_mode(100, 100, 100, 0, 3, 3);
        run(8);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0103;
        run(20);

        // Fetch across the top of the address space.
        set_mode(100, 100, 100, 0, 1, 1);
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFF0;
        run(20);
        chk("wrap_request_seen", {31'd0, saw_wrap_req}, 32'd1);
        chk("wrap_inst_seen", {31'd0, saw_wrap_inst}, 32'd1);

        // Random traffic with frequent redirects.
        set_mode(70, 70, 70, 40, 1, 4);
        run(3000);

        // Reset in the middle of traffic, then keep going.
        do_reset();
        set_mode(75, 80, 80, 20, 1, 3);
        run(1000);

        chk("progress", {31'd0, (delivered > 200)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
